turnstile_access_ctrl: RTL
==========================

Name: turnstile_access_ctrl

Overview:
- Sequencing controller for the turnstile alarm datapath (sensor S; buzzer, light, vibrator, display).
- Decides when a passage is legitimate (credential presented first) and when it is an intrusion.
- Raises a single ALARM level that enables the existing buzzer/light/vibrator/display path.
- Drives the gate lock and keeps a count of authorised passages.

Parameters:
DEB_CYC, 500000, cycles debounced S must be stable before a level change is accepted (10 ms at 50 MHz)
UNLOCK_CYC, 250000000, cycles gate stays unlocked waiting for entry after a credential (5 s)
PASS_CYC, 150000000, maximum cycles S may stay active during an authorised passage (3 s)
ALARM_CYC, 100000000, minimum cycles ALARM is held once raised (2 s)
HOLD_CYC, 50000000, post-alarm holdoff during which inputs are ignored (1 s)

Ports:
CLK  input  1  system clock, 50 MHz
RST_N  input  1  asynchronous active-low reset
S  input  1  raw presence sensor, asynchronous to CLK, active high
CARD  input  1  valid-credential pulse, synchronous, one or more cycles high
ACK  input  1  guard acknowledge, synchronous, level
UNLOCK  output  1  gate release, 1 = unlocked
ALARM  output  1  alarm enable to buzzer/light/vibrator/display path
BUSY  output  1  1 in any state other than IDLE
STATE  output  3  encoded state (IDLE=0, ARMED=1, PASSING=2, ALARM=3, HOLDOFF=4)
PASS_CNT  output  16  authorised passages completed, saturating

Behaviour:
- Reset (RST_N=0, async): state=IDLE, UNLOCK=0, ALARM=0, BUSY=0, STATE=0, PASS_CNT=0. Synchronizer, debounce counter, debounced S (=0) and timer are all cleared. Reset mid-operation aborts any state, including ALARM, with no residual output.
- Input conditioning:
  - S passes through a 2-flop synchronizer.
  - Debounced S changes only after the synchronized value differs from it for DEB_CYC consecutive cycles. Any mismatch-free cycle restarts the debounce count.
  - Rise and fall events are single-cycle pulses on debounced S transitions.
- Timer: one shared down-counter, loaded on every state entry with that state's limit. "Expires" means it reaches 0.
- Outputs: registered Moore decode of state, valid the cycle after the state register updates.
  - UNLOCK=1 in ARMED and PASSING.
  - ALARM=1 only in ALARM.
- State transitions:
  - IDLE: S rise -> ALARM (forced entry). Otherwise CARD=1 -> ARMED. If CARD and S rise occur in the same cycle, S wins -> ALARM.
  - ARMED: S rise -> PASSING. Timer expiry with no rise -> IDLE. CARD is ignored and does not extend the window. S rise and expiry in the same cycle -> PASSING.
  - PASSING: S fall -> IDLE and PASS_CNT+1, holding at 16'hFFFF. Timer expiry (PASS_CYC) before the fall -> ALARM (loitering/tailgating); no count. Fall and expiry in the same cycle -> IDLE with count.
  - ALARM: held for at least ALARM_CYC. After expiry, exits to HOLDOFF only when ACK=1 and debounced S=0. ACK before expiry is ignored, even if held high through expiry; ACK is re-sampled every cycle after expiry. CARD is ignored.
  - HOLDOFF: CARD, S events and ACK are all ignored. Timer expiry -> IDLE. If debounced S is still 1 on entry to IDLE, no rise occurs, so no false alarm is raised until S falls and rises again.
- Undefined STATE encodings (5-7) recover to IDLE on the next clock.

Test Plan (sim params DEB_CYC=4, UNLOCK_CYC=100, PASS_CYC=50, ALARM_CYC=20, HOLD_CYC=10):
1. Reset then idle: RST_N low 3 cycles, release, S=0, CARD=0 for 200 cycles -> STATE=0, UNLOCK=0, ALARM=0, PASS_CNT=0 throughout.
2. Authorised passage: CARD pulse 1 cycle, S high 30 cycles starting 10 cycles later, then low -> STATE 1 then 2 then 0; UNLOCK=1 from 1 cycle after CARD until IDLE; PASS_CNT=1; ALARM never 1.
3. Forced entry and ack: S high with no CARD -> ALARM=1 at 2+4+1 cycles after S. ACK held high from cycle 5 of ALARM -> no exit before 20 cycles. Drop S, then ALARM clears once expired and S is debounced low; STATE=4 for 10 cycles, then 0.
4. Timeouts: CARD with no S for 100 cycles -> IDLE and UNLOCK=0 at expiry. CARD then S held 60 cycles -> ALARM at 50 cycles into PASSING; PASS_CNT unchanged.
5. Glitch and simultaneous events: S pulses of 3 cycles -> no state change. CARD and debounced S rise in the same cycle from IDLE -> ALARM.
6. Saturation and async reset: force PASS_CNT to 65535 via repeated passages (or a bench-accelerated count), one more passage -> stays 65535. Assert RST_N low mid-ALARM, non-aligned to CLK -> ALARM=0 and STATE=0 immediately.

Source files
------------

// File: rtl/turnstile_access_ctrl_if.sv
// Sensor, credential and guard inputs plus lock/alarm/status outputs of the
// turnstile access controller.
interface turnstile_access_ctrl_if;
  logic        S;
  logic        CARD;
  logic        ACK;
  logic        UNLOCK;
  logic        ALARM;
  logic        BUSY;
  logic [2:0]  STATE;
  logic [15:0] PASS_CNT;

  modport master (
    output S, CARD, ACK,
    input  UNLOCK, ALARM, BUSY, STATE, PASS_CNT
  );

  modport slave (
    input  S, CARD, ACK,
    output UNLOCK, ALARM, BUSY, STATE, PASS_CNT
  );
endinterface

// File: rtl/turnstile_access_ctrl.sv
// Turnstile sequencing controller: conditions the presence sensor, separates
// credentialed passages from intrusions, drives the gate lock, alarm and pass count.
module turnstile_access_ctrl #(
  parameter int unsigned DEB_CYC    = 500000,
  parameter int unsigned UNLOCK_CYC = 250000000,
  parameter int unsigned PASS_CYC   = 150000000,
  parameter int unsigned ALARM_CYC  = 100000000,
  parameter int unsigned HOLD_CYC   = 50000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  turnstile_access_ctrl_if.slave tif
);

  localparam int unsigned MAX_UP = (UNLOCK_CYC > PASS_CYC) ? UNLOCK_CYC : PASS_CYC;
  localparam int unsigned MAX_AH = (ALARM_CYC > HOLD_CYC) ? ALARM_CYC : HOLD_CYC;
  localparam int unsigned MAX_T  = (MAX_UP > MAX_AH) ? MAX_UP : MAX_AH;
  localparam int unsigned TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int unsigned DW     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  // Timer is loaded with limit-1 so each timed state lasts exactly its limit.
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] T_PASS   = TW'(PASS_CYC - 1);
  localparam logic [TW-1:0] T_ALARM  = TW'(ALARM_CYC - 1);
  localparam logic [TW-1:0] T_HOLD   = TW'(HOLD_CYC - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(DEB_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PASSING = 3'd2,
    ST_ALARM   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  logic          s_meta;
  logic          s_sync;
  logic          s_deb;
  logic [DW-1:0] deb_cnt;
  logic          deb_flip;
  logic          s_rise;
  logic          s_fall;

  state_t        state;
  logic [TW-1:0] timer;
  logic          expired;
  logic [15:0]   pass_cnt;
  logic          unlock_q;
  logic          alarm_q;
  logic          busy_q;
  logic [2:0]    state_q;

  // Events fire in the same cycle the debounced level is updated.
  assign deb_flip = (s_sync != s_deb) && (deb_cnt == D_LAST);
  assign s_rise   = deb_flip &&  s_sync;
  assign s_fall   = deb_flip && !s_sync;
  assign expired  = (timer == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_meta  <= 1'b0;
      s_sync  <= 1'b0;
      s_deb   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s_meta <= tif.S;
      s_sync <= s_meta;
      if (s_sync == s_deb) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        s_deb   <= s_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      timer    <= '0;
      pass_cnt <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= '0;
    end else begin
      unlock_q <= (state == ST_ARMED) || (state == ST_PASSING);
      alarm_q  <= (state == ST_ALARM);
      busy_q   <= (state != ST_IDLE);
      state_q  <= state;

      if (!expired) begin
        timer <= timer - TW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (s_rise) begin
            state <= ST_ALARM;
            timer <= T_ALARM;
          end else if (tif.CARD) begin
            state <= ST_ARMED;
            timer <= T_UNLOCK;
          end
        end
        ST_ARMED: begin
          if (s_rise) begin
            state <= ST_PASSING;
            timer <= T_PASS;
          end else if (expired) begin
            state <= ST_IDLE;
            timer <= '0;
          end
        end
        ST_PASSING: begin
          if (s_fall) begin
            state    <= ST_IDLE;
            timer    <= '0;
            pass_cnt <= (pass_cnt == '1) ? pass_cnt : pass_cnt + 16'd1;
          end else if (expired) begin
            state <= ST_ALARM;
            timer <= T_ALARM;
          end
        end
        ST_ALARM: begin
          if (expired && tif.ACK && !s_deb) begin
            state <= ST_HOLDOFF;
            timer <= T_HOLD;
          end
        end
        ST_HOLDOFF: begin
          if (expired) begin
            state <= ST_IDLE;
            timer <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign tif.UNLOCK   = unlock_q;
  assign tif.ALARM    = alarm_q;
  assign tif.BUSY     = busy_q;
  assign tif.STATE    = state_q;
  assign tif.PASS_CNT = pass_cnt;

endmodule
